i2c_slave_rx: RTL
=================

// Module: i2c_slave_rx
// PURPOSE
//  I2C target (slave) receiver: the far end of our 200 kHz I2C master link.
//  Watches SCL/SDA, detects START/STOP, matches a 7-bit device address, ACKs
//  write bytes by pulling SDA low, and emits each received byte plus 16-bit
//  word pairs (WM8731-style {reg[6:0],data[8:0]}). Used as an on-chip codec
//  model and loopback checker for the master. Write-only; reads are NACKed.
// PARAMETERS
//  DEV_ADDR    7'h1A  7-bit address answered (wire byte 0x34 = write)
//  FILTER_LEN  3      clk cycles a synced SCL/SDA level must hold to be accepted (>=1)
// PORTS
//  clk         in   1   system clock, 50 MHz
//  reset       in   1   asynchronous, active-high
//  scl_in      in   1   raw SCL pin level (asynchronous)
//  sda_in      in   1   raw SDA pin level (asynchronous)
//  sda_oe      out  1   1 = drive SDA low (open-drain); 0 = release
//  rx_data     out  8   last received data byte (address byte excluded)
//  rx_valid    out  1   1-cycle strobe, rx_data updated
//  word        out  16  {first byte, second byte} of current pair
//  word_valid  out  1   1-cycle strobe, word updated
//  busy        out  1   1 from address match until STOP/START
//  stop_seen   out  1   1-cycle strobe on every STOP
//  addr_nack   out  1   1-cycle strobe: addressed with R/W=1 (read), NACKed
// BEHAVIOUR
//  Reset (async): sda_oe=0, rx_data=0, rx_valid=0, word=0, word_valid=0,
//   busy=0, stop_seen=0, addr_nack=0; state IDLE; sync/filters load 1 (bus idle).
//  Input path: 2-FF synchronizer per line, then filter: filtered level changes
//   only after FILTER_LEN consecutive equal synced samples. Edges = filtered
//   level vs. previous filtered level. Pin-to-edge latency 2+FILTER_LEN cycles.
//  START: SDA fall while SCL=1. STOP: SDA rise while SCL=1. Both take priority
//   over bit sampling and are honoured in every state (repeated START included).
//  Bits sampled MSB-first on SCL rising edge; bit counter 0..7 per byte.
//  States:
//   IDLE     - wait START -> ADDR.
//   ADDR     - shift 8 bits. On 8th rise: addr==DEV_ADDR & R/W=0 -> A_ACK,
//              busy=1; addr==DEV_ADDR & R/W=1 -> addr_nack strobe, IGNORE;
//              mismatch -> IGNORE.
//   A_ACK    - SCL fall after 8th bit: sda_oe=1; SCL fall after 9th: sda_oe=0,
//              -> DATA.
//   DATA     - shift 8 bits; on 8th rise: rx_data<=byte, rx_valid next cycle;
//              byte-pair phase toggles; 2nd byte -> word<={hi,lo}, word_valid
//              same cycle as rx_valid. -> D_ACK.
//   D_ACK    - same ACK timing as A_ACK, -> DATA.
//   IGNORE   - sda_oe held 0; wait START/STOP.
//  START in any state: sda_oe=0 at once, bit counter=0, pair phase cleared,
//   busy=0, -> ADDR. STOP in any state: sda_oe=0, busy=0, stop_seen strobe,
//   unpaired byte discarded (no word_valid), -> IDLE.
//  Mid-byte START/STOP discards partial byte (no rx_valid).
//  ACK drive begins >=1 clk after SCL low detected; SDA never changes while
//   filtered SCL is high (except via reset).
//  Reset asserted mid-ACK: sda_oe drops asynchronously to 0.
//  Strobes are exactly 1 clk wide; never back-to-back for one byte.
// TESTING
//  1 START,0x34,0x1E,0x00,STOP -> 3 ACK slots with sda_oe=1 during SCL high;
//    rx_valid x2 (0x1E,0x00); word_valid once, word=16'h1E00; stop_seen once.
//  2 START,0x36,0xAA,STOP -> sda_oe never 1; no rx_valid/word_valid; busy stays 0.
//  3 START,0x35 -> addr_nack strobe, 9th SCL SDA released (NACK), IGNORE till STOP.
//  4 START,0x34,0x12, START mid-byte,0x34,0x56,0x78,STOP -> rx_valid 0x12,0x56,
//    0x78; word=16'h5678 only; partial byte dropped.
//  5 2-cycle SDA low glitch with SCL high (FILTER_LEN=3) -> no START, state IDLE.
//  6 reset pulse during A_ACK with sda_oe=1 -> sda_oe=0 same cycle, all outputs 0.

Source files
------------

// File: rtl/i2c_slave_rx_if.sv
// Pin and receive-side signals of the I2C target receiver; the master modport
// drives the raw pins and observes the decoded outputs.
interface i2c_slave_rx_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] word;
  logic        word_valid;
  logic        busy;
  logic        stop_seen;
  logic        addr_nack;

  modport master (
    output scl_in, sda_in,
    input  sda_oe, rx_data, rx_valid, word, word_valid, busy, stop_seen, addr_nack
  );

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, rx_data, rx_valid, word, word_valid, busy, stop_seen, addr_nack
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: address match, ACK, byte and 16-bit word output.
// Pin-to-edge latency 2+FILTER_LEN clk; no backpressure, strobes are fire-and-forget.
module i2c_slave_rx #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         FILTER_LEN = 3
) (
  input logic          clk,
  input logic          reset,
  i2c_slave_rx_if.slave bus
);
  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  typedef enum logic [2:0] {IDLE, ADDR, A_ACK, DATA, D_ACK, IGNORE} state_t;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]    s1, s2, filt, prev;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '1;
      s2   <= '1;
      filt <= '1;
      prev <= '1;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1   <= {bus.sda_in, bus.scl_in};
      s2   <= s1;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_rise  =  filt[0] & ~prev[0];
  assign scl_fall  = ~filt[0] &  prev[0];
  assign start_det = scl_f & ~filt[1] &  prev[1];
  assign stop_det  = scl_f &  filt[1] & ~prev[1];

  state_t      state;
  logic [6:0]  sr;
  logic [2:0]  bit_cnt;
  logic        phase;
  logic [7:0]  hi_byte;
  logic        sda_oe_r, rx_valid_r, word_valid_r, busy_r, stop_seen_r, addr_nack_r;
  logic [7:0]  rx_data_r;
  logic [15:0] word_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      phase        <= 1'b0;
      hi_byte      <= '0;
      sda_oe_r     <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      word_r       <= '0;
      word_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      stop_seen_r  <= 1'b0;
      addr_nack_r  <= 1'b0;
    end else begin
      rx_valid_r   <= 1'b0;
      word_valid_r <= 1'b0;
      stop_seen_r  <= 1'b0;
      addr_nack_r  <= 1'b0;
      if (stop_det) begin
        sda_oe_r    <= 1'b0;
        busy_r      <= 1'b0;
        stop_seen_r <= 1'b1;
        bit_cnt     <= '0;
        phase       <= 1'b0;
        state       <= IDLE;
      end else if (start_det) begin
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
        bit_cnt  <= '0;
        phase    <= 1'b0;
        state    <= ADDR;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sr      <= {sr[5:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // sr holds the 7 address bits; sda_f is R/W.
              if (sr == DEV_ADDR && !sda_f) begin
                busy_r <= 1'b1;
                state  <= A_ACK;
              end else begin
                addr_nack_r <= (sr == DEV_ADDR);
                state       <= IGNORE;
              end
            end
          end
          A_ACK, D_ACK: if (scl_fall) begin
            // First fall opens the ACK slot, second fall closes it.
            if (!sda_oe_r) begin
              sda_oe_r <= 1'b1;
            end else begin
              sda_oe_r <= 1'b0;
              bit_cnt  <= '0;
              state    <= DATA;
            end
          end
          DATA: if (scl_rise) begin
            sr      <= {sr[5:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_r  <= {sr, sda_f};
              rx_valid_r <= 1'b1;
              if (phase) begin
                word_r       <= {hi_byte, sr, sda_f};
                word_valid_r <= 1'b1;
              end else begin
                hi_byte <= {sr, sda_f};
              end
              phase <= ~phase;
              state <= D_ACK;
            end
          end
          IDLE, IGNORE: sda_oe_r <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe     = sda_oe_r;
  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.word       = word_r;
  assign bus.word_valid = word_valid_r;
  assign bus.busy       = busy_r;
  assign bus.stop_seen  = stop_seen_r;
  assign bus.addr_nack  = addr_nack_r;
endmodule
